dmem_access_ctrl: RTL
=====================

# dmem_access_ctrl

Multi-cycle data-memory access sequencer for the MEM stage of the 5-stage pipeline. It turns a load or store in MEM into a req/ack transaction on the data-memory bus and freezes the pipeline until the transaction completes. It also holds the returned load word stable for the WB-stage writeback mux (memory-data input, MemtoReg = 01). A wait-cycle timeout prevents a dead memory from hanging the core.

## Interface
- MAX_WAIT, default 15: maximum number of cycles dmem_req may stay high without dmem_ack before the access is aborted (legal range 1..255).
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_rd_MEM  in  1  instruction in MEM is a load
- mem_wr_MEM  in  1  instruction in MEM is a store
- addr_MEM  in  32  effective address from EX/MEM ALU result
- wdata_MEM  in  32  store data from EX/MEM
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  bus write enable, registered
- dmem_addr  out  32  bus address, registered
- dmem_wdata  out  32  bus write data, registered
- dmem_ack  in  1  bus completion, one-cycle pulse
- dmem_rdata  in  32  bus read data, valid when dmem_ack=1
- stall_pipe  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers
- load_data  out  32  captured load word, feeds the MEM/WB data register
- load_valid  out  1  one-cycle pulse: access finished, load_data valid
- timeout_err  out  1  sticky abort flag, cleared only by rst

## Operation
- States: IDLE, BUSY, DONE. Encoding is free.
- IDLE:
  - If mem_rd_MEM or mem_wr_MEM is high, latch addr_MEM and wdata_MEM into dmem_addr and dmem_wdata.
  - Set dmem_we = mem_wr_MEM & ~mem_rd_MEM.
  - Set dmem_req=1 and clear the wait counter, then go to BUSY.
  - Otherwise stay in IDLE.
- Simultaneous rd and wr is illegal. The load wins and no write is issued.
- BUSY:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held constant.
  - On dmem_ack=1: capture dmem_rdata into load_data (loads only; stores leave load_data unchanged), drop dmem_req, go to DONE.
  - Otherwise increment the wait counter. When the counter reaches MAX_WAIT with no ack, drop dmem_req, set load_data=0, set timeout_err=1, go to DONE.
- DONE:
  - load_valid=1 for exactly this cycle.
  - Go to IDLE unconditionally. mem_rd_MEM and mem_wr_MEM are not sampled in DONE, so the same instruction is never re-issued.
- dmem_ack is ignored in IDLE and DONE.
- stall_pipe = (IDLE & (mem_rd_MEM | mem_wr_MEM)) | BUSY. It is combinational so the pipeline freezes in the same cycle the access is detected. It is low in DONE, so the pipeline advances at the end of DONE.
- load_data holds its value until the next completed load or timeout.
- Wait counter is 8 bits and saturates. It never wraps.
- Reset values (sync rst, at any state including mid-BUSY):
  - state=IDLE
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0
  - load_data=0, load_valid=0, timeout_err=0, counter=0
- After a reset the aborted access is not retried. Any late ack is ignored.

## Timing
- Cycle N: access in MEM while in IDLE. stall_pipe=1 combinationally.
- Edge after N: dmem_req=1 visible in N+1.
- Ack sampled in cycle M ≥ N+1. DONE is in M+1 with load_valid=1, stall_pipe=0 and load_data valid. The next instruction enters MEM in M+2.
- Minimum occupancy of MEM per access is 3 cycles (N, N+1, N+2 with ack in N+1).
- Back-to-back accesses: the second access is detected in IDLE at M+2 at the earliest. There are no bubbles other than the DONE cycle.
- Timeout: with no ack, dmem_req is high for exactly MAX_WAIT cycles. DONE follows, with timeout_err rising in the same cycle as load_valid.
- A non-memory instruction in MEM while in IDLE gives stall_pipe=0 and no bus activity.

## Test plan
- Load, ack in first BUSY cycle, addr=0x0000_0010, rdata=0xDEAD_BEEF:
  - stall_pipe high for 2 cycles, dmem_we=0.
  - load_valid pulse in cycle 3 with load_data=0xDEAD_BEEF.
- Store with ack after 4 wait cycles, addr=0x20, wdata=0x1234_5678:
  - dmem_we=1, and addr/data stable for all 5 req cycles.
  - load_data unchanged; stall_pipe drops in DONE.
- Load with no ack, MAX_WAIT=15:
  - dmem_req high for exactly 15 cycles.
  - Then load_valid=1, load_data=0, timeout_err=1, which stays high until rst.
- Two consecutive loads (rdata 0x1, then 0x2):
  - Two distinct req phases separated by the DONE and IDLE cycles.
  - load_valid pulses carry 0x1 then 0x2; no duplicate request.
- rst asserted during BUSY:
  - Next cycle dmem_req=0, stall_pipe=0 (with no MEM access present).
  - A subsequent stray dmem_ack produces no load_valid.
- mem_rd_MEM and mem_wr_MEM both high: dmem_we=0 and the access completes as a load.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Purpose  : MEM-stage data-memory req/ack sequencer with pipeline stall,
//            load-word capture and wait-cycle timeout.
// Revision : 1.0
// ============================================================================
module dmem_access_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_MEM,
  input  logic        mem_wr_MEM,
  input  logic [31:0] addr_MEM,
  input  logic [31:0] wdata_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_pipe,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter value seen during the last permitted request cycle.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        timeout_err_q, timeout_err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    load_data_d   = load_data_q;
    load_valid_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mem_rd_MEM || mem_wr_MEM) begin
          addr_d  = addr_MEM;
          wdata_d = wdata_MEM;
          we_d    = mem_wr_MEM & ~mem_rd_MEM;
          req_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // An ack on the final permitted cycle still wins over the timeout.
        if (dmem_ack) begin
          if (!we_q) load_data_d = dmem_rdata;
          req_d        = 1'b0;
          load_valid_d = 1'b1;
          state_d      = S_DONE;
        end else if (cnt_q == WAIT_LAST) begin
          req_d         = 1'b0;
          load_data_d   = 32'd0;
          timeout_err_d = 1'b1;
          load_valid_d  = 1'b1;
          cnt_d         = cnt_inc;
          state_d       = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      load_data_q   <= 32'd0;
      load_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      load_data_q   <= load_data_d;
      load_valid_q  <= load_valid_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  // Combinational so the pipeline freezes in the cycle the access appears.
  assign stall_pipe  = ((state_q == S_IDLE) && (mem_rd_MEM || mem_wr_MEM)) ||
                       (state_q == S_BUSY);
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign load_data   = load_data_q;
  assign load_valid  = load_valid_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire
